hazard_detection_unit: RTL and testbench
========================================

Name: hazard_detection_unit

Overview:
Decode-stage hazard/stall controller. It sits alongside the forwarding unit, upstream of the ID/EX pipeline register, and drives the PC, IF/ID and ID/EX write/flush controls. It detects load-use and JALR-on-load dependencies that forwarding cannot cover, and holds multi-cycle stalls with a small FSM. It also arbitrates stalls against memory-wait freezes and EX-stage redirects, and keeps a saturating stall-cycle counter.

Parameters:
CNT_W, 16, width of stall-cycle performance counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rs1  in  5  ID-stage source register 1
rs2  in  5  ID-stage source register 2
uses_rs2  in  1  ID instruction reads rs2 (R/S/B type)
jalr  in  1  ID instruction is JALR (target computed in ID)
ID_EX_rd  in  5  destination of instruction in EX
ID_EX_memread  in  1  instruction in EX is a load
EX_MEM_rd  in  5  destination of instruction in MEM
EX_MEM_memread  in  1  instruction in MEM is a load
mem_stall  in  1  I/D cache not ready; whole pipeline must freeze
redirect  in  1  EX-stage mispredict; fetch restarts at corrected PC
pc_write  out  1  PC register load enable
IF_ID_write  out  1  IF/ID register load enable
IF_ID_flush  out  1  clear IF/ID to NOP
ID_EX_write  out  1  ID/EX register load enable
ID_EX_bubble  out  1  load NOP into ID/EX instead of ID contents
stall_cycles  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Hazard terms (combinational; rd==0 never hazards):
  - lu = ID_EX_memread & ID_EX_rd!=0 & (ID_EX_rd==rs1 | (uses_rs2 & ID_EX_rd==rs2))
  - jx = jalr & ID_EX_memread & ID_EX_rd!=0 & ID_EX_rd==rs1 (needs 2 bubbles)
  - jm = jalr & EX_MEM_memread & EX_MEM_rd!=0 & EX_MEM_rd==rs1 (needs 1 bubble)
- FSM states:
  - RUN
  - HOLD: exactly one further stall cycle pending
- Priority per cycle: rst > mem_stall > redirect > HOLD > hazard > normal.
- mem_stall=1:
  - pc_write=IF_ID_write=ID_EX_write=0; flush/bubble=0.
  - FSM state and counter frozen.
  - redirect and hazards are ignored this cycle.
- redirect=1 (no mem_stall):
  - pc_write=1, IF_ID_flush=1, ID_EX_write=1, ID_EX_bubble=1.
  - FSM -> RUN, cancelling any HOLD.
  - Not counted as a stall.
- State HOLD (no mem_stall/redirect):
  - Outputs pc_write=0, IF_ID_write=0, ID_EX_write=1, ID_EX_bubble=1.
  - Next state RUN; hazard terms not re-evaluated.
- State RUN with lu|jx|jm:
  - Same stall outputs as HOLD in the same cycle, with no latency.
  - Next state is HOLD if jx, else RUN.
- State RUN with no hazard: pc_write=IF_ID_write=ID_EX_write=1; flush/bubble=0.
- stall_cycles:
  - Increments on every cycle with ID_EX_bubble=1 and redirect=0.
  - Saturates at 2^CNT_W-1; never wraps.
- Reset (synchronous):
  - FSM=RUN, stall_cycles=0.
  - Outputs during the reset cycle: pc_write=IF_ID_write=ID_EX_write=0, flush=bubble=0.
  - Reset mid-HOLD discards the pending stall.
- Only the FSM state and the counter are registered; all other outputs are combinational.

Test Plan:
- Load-use: ID_EX_memread=1, ID_EX_rd=5, rs1=5 -> one cycle pc_write=0, IF_ID_write=0, ID_EX_bubble=1; stall_cycles 0->1; next cycle normal once the load moves to MEM.
- JALR on load in EX: jalr=1, ID_EX_memread=1, ID_EX_rd=7, rs1=7 -> two consecutive stall cycles (RUN->HOLD->RUN); stall_cycles +2. Same with load in MEM (EX_MEM_rd=7) -> one stall cycle.
- x0 and rs2 gating: ID_EX_rd=0=rs1 -> no stall. rs2 match with uses_rs2=0 -> no stall; with uses_rs2=1 -> 1 stall.
- mem_stall during HOLD: assert mem_stall 3 cycles mid-JALR stall -> all write enables 0, state stays HOLD; after release exactly one bubble cycle remains; counter unchanged during freeze.
- Redirect cancels HOLD: redirect=1 in the HOLD cycle -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1, next state RUN, counter not incremented. Redirect together with lu -> redirect outputs win.
- Saturation/reset: with CNT_W=4, force 20 stall cycles -> stall_cycles holds 15. Assert rst -> counter 0, FSM RUN on the next edge.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// Decode-stage hazard/stall controller.
// Detects load-use and JALR-on-load dependencies that forwarding cannot
// resolve, holds the two-bubble JALR case with a RUN/HOLD FSM, arbitrates
// against memory freezes and EX redirects, and counts hazard-stall cycles.
module hazard_detection_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic             uses_rs2,
    input  logic             jalr,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_memread,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             EX_MEM_memread,
    input  logic             mem_stall,
    input  logic             redirect,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_bubble,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_ex_load;
    logic w_mem_load;
    logic w_lu;
    logic w_jx;
    logic w_jm;
    logic w_cnt_inc;

    // x0 is never a real producer, so a load targeting it cannot hazard.
    assign w_ex_load  = ID_EX_memread & (ID_EX_rd != 5'd0);
    assign w_mem_load = EX_MEM_memread & (EX_MEM_rd != 5'd0);

    assign w_lu = w_ex_load & ((ID_EX_rd == rs1) | (uses_rs2 & (ID_EX_rd == rs2)));
    assign w_jx = jalr & w_ex_load & (ID_EX_rd == rs1);
    assign w_jm = jalr & w_mem_load & (EX_MEM_rd == rs1);

    // Prioritised control outputs and next state: rst > mem_stall > redirect > HOLD > hazard.
    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_write  = 1'b1;
        ID_EX_bubble = 1'b0;
        w_state_nxt  = RUN;

        if (rst) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_write = 1'b0;
            w_state_nxt = RUN;
        end else if (mem_stall) begin
            // Whole pipeline frozen; pending HOLD survives the freeze.
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_write = 1'b0;
            w_state_nxt = r_state;
        end else if (redirect) begin
            // Squash the wrong-path instructions in IF/ID and ID.
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
            w_state_nxt  = RUN;
        end else if (r_state == HOLD) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            w_state_nxt  = RUN;
        end else if (w_lu | w_jx | w_jm) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            // JALR on a load still in EX needs a second bubble.
            w_state_nxt  = w_jx ? HOLD : RUN;
        end
    end

    // Redirect bubbles are squashes, not hazard stalls, so they are not counted.
    assign w_cnt_inc = ID_EX_bubble & ~redirect & (r_stall_cycles != CNT_MAX);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Saturating hazard-stall cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_cnt_inc) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Table-driven bench for hazard_detection_unit (CNT_W=4 to reach saturation).
// Each table record is one clock cycle; records are applied in order so
// multi-cycle sequences (HOLD, freezes, redirects) follow from the table.
module tb_hazard_detection_unit;

    localparam int CNT_W = 4;

    // Packed expected outputs: {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble}
    localparam logic [4:0] O_NORM  = 5'b11010;
    localparam logic [4:0] O_STALL = 5'b00011;
    localparam logic [4:0] O_FRZ   = 5'b00000;
    localparam logic [4:0] O_REDIR = 5'b11111;
    localparam logic [4:0] O_RST   = 5'b00000;

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs2;
        logic       jalr;
        logic [4:0] idex_rd;
        logic       idex_mr;
        logic [4:0] exmem_rd;
        logic       exmem_mr;
        logic       mem_stall;
        logic       redirect;
        logic [4:0] exp_out;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             uses_rs2;
    logic             jalr;
    logic [4:0]       ID_EX_rd;
    logic             ID_EX_memread;
    logic [4:0]       EX_MEM_rd;
    logic             EX_MEM_memread;
    logic             mem_stall;
    logic             redirect;
    logic             pc_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_write;
    logic             ID_EX_bubble;
    logic [CNT_W-1:0] stall_cycles;

    int n_vec;
    int n_miss;
    logic [CNT_W-1:0] exp_cnt;
    vec_t tbl[$];

    hazard_detection_unit #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .rs1            (rs1),
        .rs2            (rs2),
        .uses_rs2       (uses_rs2),
        .jalr           (jalr),
        .ID_EX_rd       (ID_EX_rd),
        .ID_EX_memread  (ID_EX_memread),
        .EX_MEM_rd      (EX_MEM_rd),
        .EX_MEM_memread (EX_MEM_memread),
        .mem_stall      (mem_stall),
        .redirect       (redirect),
        .pc_write       (pc_write),
        .IF_ID_write    (IF_ID_write),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_write    (ID_EX_write),
        .ID_EX_bubble   (ID_EX_bubble),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                                input logic u2, input logic jr,
                                input logic [4:0] erd, input logic emr,
                                input logic [4:0] mrd, input logic mmr,
                                input logic ms, input logic rd, input logic [4:0] eo);
        vec_t v;
        v.rst = r; v.rs1 = a1; v.rs2 = a2; v.uses_rs2 = u2; v.jalr = jr;
        v.idex_rd = erd; v.idex_mr = emr; v.exmem_rd = mrd; v.exmem_mr = mmr;
        v.mem_stall = ms; v.redirect = rd; v.exp_out = eo;
        return v;
    endfunction

    // Shorthands for common cycles.
    function automatic vec_t idle(input logic [4:0] eo);
        return mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, eo);
    endfunction

    function automatic vec_t jx_vec(input logic [4:0] eo);
        return mk(0, 5'd7, 5'd0, 0, 1, 5'd7, 1, 5'd0, 0, 0, 0, eo);
    endfunction

    function automatic vec_t lu_vec(input logic [4:0] eo);
        return mk(0, 5'd5, 5'd0, 0, 0, 5'd5, 1, 5'd0, 0, 0, 0, eo);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        logic [4:0] got;
        @(negedge clk);
        rst            = v.rst;
        rs1            = v.rs1;
        rs2            = v.rs2;
        uses_rs2       = v.uses_rs2;
        jalr           = v.jalr;
        ID_EX_rd       = v.idex_rd;
        ID_EX_memread  = v.idex_mr;
        EX_MEM_rd      = v.exmem_rd;
        EX_MEM_memread = v.exmem_mr;
        mem_stall      = v.mem_stall;
        redirect       = v.redirect;
        #1;
        got = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble};
        n_vec++;
        if (got !== v.exp_out) begin
            n_miss++;
            $display("FAIL ctl vec %0d: got %b required %b", idx, got, v.exp_out);
        end
        // Reference counter: hazard bubbles only, saturating, cleared by reset.
        if (v.rst)
            exp_cnt = '0;
        else if (v.exp_out[0] && !v.redirect && exp_cnt != {CNT_W{1'b1}})
            exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (stall_cycles !== exp_cnt) begin
            n_miss++;
            $display("FAIL cnt vec %0d: got %0d required %0d", idx, stall_cycles, exp_cnt);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        exp_cnt = '0;
        rst = 1'b1; rs1 = '0; rs2 = '0; uses_rs2 = 0; jalr = 0;
        ID_EX_rd = '0; ID_EX_memread = 0; EX_MEM_rd = '0; EX_MEM_memread = 0;
        mem_stall = 0; redirect = 0;

        // Reset, then basic load-use
        tbl.push_back(mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, O_RST));
        tbl.push_back(idle(O_NORM));
        tbl.push_back(lu_vec(O_STALL));
        tbl.push_back(mk(0, 5'd5, 5'd0, 0, 0, 5'd0, 0, 5'd5, 1, 0, 0, O_NORM));
        // Non-load producer in EX does not stall
        tbl.push_back(mk(0, 5'd5, 5'd0, 0, 0, 5'd5, 0, 5'd0, 0, 0, 0, O_NORM));
        // JALR on load in EX: two bubbles; second one with idle inputs
        tbl.push_back(jx_vec(O_STALL));
        tbl.push_back(idle(O_STALL));
        tbl.push_back(idle(O_NORM));
        // JALR on load in MEM: one bubble
        tbl.push_back(mk(0, 5'd7, 5'd0, 0, 1, 5'd0, 0, 5'd7, 1, 0, 0, O_STALL));
        tbl.push_back(idle(O_NORM));
        // x0 and rs2 gating
        tbl.push_back(mk(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 5'd0, 1, 0, 0, O_NORM));
        tbl.push_back(mk(0, 5'd1, 5'd9, 0, 0, 5'd9, 1, 5'd0, 0, 0, 0, O_NORM));
        tbl.push_back(mk(0, 5'd1, 5'd9, 1, 0, 5'd9, 1, 5'd0, 0, 0, 0, O_STALL));
        tbl.push_back(idle(O_NORM));
        // mem_stall for 3 cycles during HOLD, then the remaining bubble
        tbl.push_back(jx_vec(O_STALL));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 1, 0, O_FRZ));
        tbl.push_back(idle(O_STALL));
        tbl.push_back(idle(O_NORM));
        // Redirect in the HOLD cycle cancels the pending bubble
        tbl.push_back(jx_vec(O_STALL));
        tbl.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, O_REDIR));
        tbl.push_back(idle(O_NORM));
        // Redirect beats a load-use hazard; mem_stall beats both
        tbl.push_back(mk(0, 5'd5, 5'd0, 0, 0, 5'd5, 1, 5'd0, 0, 0, 1, O_REDIR));
        tbl.push_back(mk(0, 5'd5, 5'd0, 0, 0, 5'd5, 1, 5'd0, 0, 1, 1, O_FRZ));
        tbl.push_back(idle(O_NORM));
        // Saturation: 20 load-use stalls drive the 4-bit counter to 15
        for (int i = 0; i < 20; i++)
            tbl.push_back(lu_vec(O_STALL));
        tbl.push_back(idle(O_NORM));
        // Reset mid-HOLD discards the pending bubble and clears the counter
        tbl.push_back(jx_vec(O_STALL));
        tbl.push_back(mk(1, 5'd7, 5'd0, 0, 1, 5'd7, 1, 5'd0, 0, 0, 0, O_RST));
        tbl.push_back(idle(O_NORM));
        tbl.push_back(lu_vec(O_STALL));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        // Hand-written check: counter must sit at the saturation value mid-run
        // is covered above; finally confirm the last stall counted from zero.
        n_vec++;
        if (stall_cycles !== 4'd1) begin
            n_miss++;
            $display("FAIL final cnt: got %0d required 1", stall_cycles);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
